threshold_voter: RTL
====================

# threshold_voter

Parametrised, handshaked successor to the team's 16-bit combinational majority function. Accepts a WIDTH-bit word, counts its 1 bits serially over several cycles, processing CHUNK bits per cycle, and reports the population count plus a single vote bit. The vote is either strict majority or `count >= threshold`. Sits between a valid/ready producer and consumer, so wide words do not need a single-cycle WIDTH-input adder tree.

## Interface
Parameters:
- WIDTH, default 16: input word width; must be ≥ 2.
- CHUNK, default 4: bits counted per cycle; WIDTH % CHUNK == 0 is required, otherwise elaboration error.
- CW, default $clog2(WIDTH+1): count/threshold width (derived, not overridden).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: Data/threshold/mode valid.
- in_ready, output, 1: block can accept a word.
- Data, input, WIDTH: word to vote on.
- threshold, input, CW: threshold used when mode=1.
- mode, input, 1: 0 = strict majority (count > WIDTH/2, integer division); 1 = count ≥ threshold.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer takes result.
- Out, output, 1: vote result.
- count, output, CW: number of 1s in the accepted word.

## Operation
- FSM states: IDLE, COUNT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture Data into a shift register, and capture threshold and mode.
  - Clear the accumulator and the chunk counter, then go to COUNT.
- COUNT:
  - in_ready=0.
  - Each cycle: add popcount(shift[CHUNK-1:0]) to the accumulator, shift right by CHUNK, increment the chunk counter.
  - After NCH = WIDTH/CHUNK cycles: register count and Out, set out_valid, go to DONE.
- DONE:
  - out_valid=1; Out and count are held stable.
  - On out_ready: clear out_valid and go to IDLE.
  - Without out_ready, the result is held indefinitely with no loss.
- Vote rules:
  - mode 0: Out = (count > WIDTH/2). With WIDTH=16, 9 or more ones give 1; a tie of 8 gives 0.
  - mode 1: Out = (count ≥ threshold). threshold=0 always gives 1; threshold > WIDTH always gives 0.
- Width rules:
  - The accumulator is CW bits and never overflows, since the maximum count is WIDTH.
  - The comparison is unsigned at CW bits.
- Input changes on Data/threshold/mode after acceptance have no effect on the result in flight.
- Reset mid-operation (any state) aborts the word: state IDLE, accumulator cleared.

## Timing
- Reset values: in_ready=0 while rst is asserted, 1 from the first cycle after release; out_valid=0, Out=0, count=0.
- Acceptance at edge k gives out_valid=1 after edge k+NCH, so latency is NCH cycles. Default latency is 4.
- Out and count are registered, and change only on the transition into DONE.
- Minimum initiation interval is NCH+2 cycles (IDLE accept, NCH COUNT cycles, DONE handshake).
- in_ready is asserted only in IDLE. No new word is accepted in the same cycle a result is consumed.
- out_ready is ignored outside DONE.

## Structure
- Shared package threshold_voter_pkg holds the FSM state encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the mode constants MODE_MAJ=1'b0, MODE_THR=1'b1.
- One sub-module: popcount_chunk, a parametrised CHUNK-bit combinational population count with output width $clog2(CHUNK+1). It is instantiated once in the datapath.
- Remaining logic stays in the top: FSM, shift register, accumulator, chunk counter, compare.

## Test plan
Defaults for all scenarios: WIDTH=16, CHUNK=4.
- Full word: Data=16'hFFFF, mode 0, out_ready=1 → out_valid exactly 4 cycles after acceptance; count=16, Out=1.
- Majority boundary:
  - Data=16'h5555 (8 ones), mode 0 → count=8, Out=0.
  - Data=16'h01FF (9 ones), mode 0 → count=9, Out=1.
- Threshold mode:
  - Data=16'h000F, mode 1, threshold=4 → Out=1.
  - Same word with threshold=5 → Out=0.
  - threshold=0 with Data=0 → Out=1, count=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, Out and count stay stable and in_ready=0. Assert out_ready → back to IDLE; next word accepted one cycle later.
- Input isolation: change Data to 16'h0000 during COUNT after accepting 16'hFFFF → result is still count=16.
- Reset mid-COUNT: assert rst two cycles after acceptance → out_valid=0, count=0, Out=0 immediately. After release, in_ready=1, and a new word 16'h0F0F gives count=8, Out=0 (mode 0).

Source files
------------

// File: rtl/threshold_voter_pkg.sv
// Shared definitions for the serial threshold voter: FSM state encodings
// and the vote-mode constants used by the datapath and its users.
package threshold_voter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_MAJ = 1'b0;  // strict majority: count > WIDTH/2
    localparam logic MODE_THR = 1'b1;  // threshold: count >= threshold

endpackage

// File: rtl/threshold_voter_if.sv
// Valid/ready handshake bundle between producer, voter and consumer.
// The master modport is the environment (producer + consumer); the slave
// modport is the voter itself.
interface threshold_voter_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Data;
    logic [CW-1:0]    threshold;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic             Out;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, Data, threshold, mode, out_ready,
        input  in_ready, out_valid, Out, count
    );

    modport slave (
        input  in_valid, Data, threshold, mode, out_ready,
        output in_ready, out_valid, Out, count
    );
endinterface

// File: rtl/threshold_voter_popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice of the word.
module popcount_chunk #(
    parameter  int CHUNK = 4,
    localparam int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits_i,
    output logic [PW-1:0]    ones_o
);

    // Sum the individual bits of the slice.
    always_comb begin
        ones_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones_o = ones_o + PW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/threshold_voter.sv
// Serial threshold/majority voter: accepts a WIDTH-bit word over a
// valid/ready handshake, counts its ones CHUNK bits per cycle and presents
// a registered count plus vote bit until the consumer takes it.
module threshold_voter
    import threshold_voter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CHUNK = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    threshold_voter_if.slave bus
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = $clog2(CHUNK + 1);

    localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCH - 1);
    localparam logic [CW-1:0]   HALF       = CW'(WIDTH / 2);

    // Parameter sanity: an uneven split would leave bits uncounted.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("threshold_voter: WIDTH must be >= 2");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("threshold_voter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [CW-1:0]     acc_q;
    logic [CNTW-1:0]   chunk_q;
    logic [CW-1:0]     thr_q;
    logic              mode_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_q;
    logic [CW-1:0]     count_q;

    logic [PW-1:0]     pc_s;
    logic [CW-1:0]     sum_d;
    logic              vote_d;

    popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
        .bits_i (shift_q[CHUNK-1:0]),
        .ones_o (pc_s)
    );

    // Running total including the current slice, and the vote it implies.
    always_comb begin
        sum_d = acc_q + CW'(pc_s);
        if (mode_q == MODE_THR) begin
            vote_d = (sum_d >= thr_q);
        end else begin
            vote_d = (sum_d > HALF);
        end
    end

    // Control FSM with the shift register, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            chunk_q     <= '0;
            thr_q       <= '0;
            mode_q      <= MODE_MAJ;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    // in_ready_q is still low on the first cycle after reset
                    if (bus.in_valid && in_ready_q) begin
                        shift_q    <= bus.Data;
                        thr_q      <= bus.threshold;
                        mode_q     <= bus.mode;
                        acc_q      <= '0;
                        chunk_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= COUNT;
                    end
                end
                COUNT: begin
                    acc_q   <= sum_d;
                    shift_q <= shift_q >> CHUNK;
                    chunk_q <= chunk_q + CNTW'(1);
                    if (chunk_q == LAST_CHUNK) begin
                        count_q     <= sum_d;
                        out_q       <= vote_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it; the
                    // next word is accepted no earlier than the following cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Out       = out_q;
    assign bus.count     = count_q;

endmodule
